usb_tx_sched: RTL

USB_TX_SCHED -- requirements
Module: usb_tx_sched

---
 rtl/usb_tx_sched.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/usb_tx_sched.sv
// Two-requester round-robin transmit scheduler. Each packet gets a CRC-16/USB
// trailer (low byte first) and is followed by a fixed number of idle cycles.
module usb_tx_sched #(
  parameter int unsigned GAP = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic       last0,
  input  logic       last1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       gnt
);

  localparam int unsigned CRC_W = 16;
  localparam int unsigned GAP_W = 4;
  localparam logic [CRC_W-1:0] CRC_INIT = 16'hFFFF;
  localparam logic [CRC_W-1:0] CRC_POLY = 16'hA001;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_CRC_LO,
    ST_CRC_HI,
    ST_GAP
  } state_e;

  state_e           state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             ptr_q, ptr_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic       own_req;
  logic       own_last;
  logic [7:0] own_data;

  // One byte of reflected CRC-16 (LSB first).
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc,
                                                input logic [7:0]       din);
    logic [CRC_W-1:0] c;
    c = crc ^ {8'h00, din};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  assign own_req  = gnt_q ? req1  : req0;
  assign own_last = gnt_q ? last1 : last0;
  assign own_data = gnt_q ? data1 : data0;
  assign busy     = (state_q != ST_IDLE);
  assign gnt      = gnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b0;
      ptr_q   <= 1'b1;
      crc_q   <= CRC_INIT;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      crc_q   <= crc_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    ptr_d    = ptr_q;
    crc_d    = crc_q;
    gap_d    = gap_q;
    tx_valid = 1'b0;
    tx_data  = '0;
    ack0     = 1'b0;
    ack1     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          // On contention the requester not served last wins.
          gnt_d   = (req0 && req1) ? ~ptr_q : req1;
          crc_d   = CRC_INIT;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        tx_valid = own_req;
        if (own_req) begin
          tx_data = own_data;
        end
        if (own_req && tx_ready) begin
          ack0  = ~gnt_q;
          ack1  = gnt_q;
          crc_d = crc_step(crc_q, own_data);
          if (own_last) begin
            ptr_d   = gnt_q;
            state_d = ST_CRC_LO;
          end
        end
      end
      ST_CRC_LO: begin
        tx_valid = 1'b1;
        tx_data  = ~crc_q[7:0];
        if (tx_ready) begin
          state_d = ST_CRC_HI;
        end
      end
      ST_CRC_HI: begin
        tx_valid = 1'b1;
        tx_data  = ~crc_q[15:8];
        if (tx_ready) begin
          if (GAP == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
            gap_d   = GAP_LOAD;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
